bottom_linear_pipe: RTL and testbench
=====================================

BOTTOM_LINEAR_PIPE -- requirements
Module: bottom_linear_pipe

Interface
REQ-001 Parameter LANES, default 4: number of independent byte lanes; legal range 1..16.
REQ-002 Parameter PIPE_STAGES, default 2: number of register stages between input and output; legal range 1..4.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  input beat present.
REQ-006 in_ready  output  1  block accepts the input beat this cycle.
REQ-007 in_m  input  63*LANES  per-lane nonlinear products M0..M62; lane k occupies bits [63k+62:63k].
REQ-008 out_valid  output  1  output beat present.
REQ-009 out_ready  input  1  downstream accepts the output beat this cycle.
REQ-010 out_w  output  8*LANES  per-lane inverse-S-box bottom-linear result; lane k occupies bits [8k+7:8k].
REQ-011 beat_count  output  32  number of completed output handshakes.

Function
REQ-012 Each lane computes the depth-16 reverse bottom linear transform: 29 GF(2) intermediates P0..P28, then eight output bits W, over XOR only, with no constant term.
REQ-013 The transform for lane k depends only on lane k of in_m; there is no cross-lane mixing.
REQ-014 The input handshake occurs when in_valid and in_ready are both high; the output handshake occurs when out_valid and out_ready are both high.
REQ-015 The pipeline is a valid/ready chain of PIPE_STAGES stages. A stage loads when it is empty or when its contents move forward in the same cycle.
REQ-016 Latency is exactly PIPE_STAGES cycles from the input handshake to out_valid when out_ready stays high.
REQ-017 Throughput is one beat per cycle while out_ready stays high; there are no bubbles inserted.
REQ-018 in_ready is high when stage 0 is empty or stage 0 advances this cycle; a combinational path from out_ready to in_ready is permitted.
REQ-019 While out_valid is high and out_ready is low, out_w and out_valid hold stable until the handshake occurs.
REQ-020 When the pipeline is full and out_ready is low, in_ready is low, no beat is dropped, and no beat is duplicated.
REQ-021 A simultaneous output handshake and input handshake on a full pipeline keeps occupancy unchanged.
REQ-022 Beats leave in the same order they arrived.
REQ-023 beat_count increments by 1 on each output handshake and wraps from 0xFFFFFFFF to 0.
REQ-024 Data registers in empty stages are don't-care; out_w is observed only while out_valid is high.

Reset
REQ-025 While rst is high, all stage valid bits clear, out_valid is 0, and beat_count is 0 at the next clock edge.
REQ-026 While rst is high, in_ready is 0.
REQ-027 Reset asserted mid-stream discards all in-flight beats, and no output handshake completes in that cycle.
REQ-028 Data registers need not be reset.

Structure
REQ-029 Shared package sbox_pkg holds M_WIDTH=63, W_WIDTH=8, P_COUNT=29 and the lane-count limits.
REQ-030 The per-lane combinational transform lives in a single sub-module, bottom_linear_reverse, instantiated LANES times.
REQ-031 Pipeline registers are placed after the transform so that synthesis may retime them.
REQ-032 No latches are permitted, and no logic is clocked on the negative edge.

Verification
REQ-033 Single-bit response (LANES=1, PIPE_STAGES=2): in_m = 0 -> out_w = 0x00; in_m bit 62 only -> out_w = 0x49; in_m bit 51 only -> out_w = 0xFE; each appears 2 cycles after acceptance.
REQ-034 Linearity: random in_m pairs A and B across 10k beats, per lane -> out(A xor B) = out(A) xor out(B); lanes are independent when LANES=4.
REQ-035 Backpressure: stream 16 beats with out_ready toggled pseudo-randomly -> all 16 results arrive in order, and out_w stays stable during every stall.
REQ-036 Full pipeline: hold out_ready low for 10 cycles while in_valid stays high -> in_ready falls after PIPE_STAGES accepts; release out_ready -> remaining beats drain with no loss.
REQ-037 Reset mid-stream: assert rst for 1 cycle with 3 beats in flight -> out_valid = 0 and beat_count = 0 on the next cycle; the next accepted beat emerges normally.
REQ-038 Counter wrap: force beat_count to 0xFFFFFFFE, complete 3 handshakes -> beat_count reads 0x00000001.

Source files
------------

// File: rtl/sbox_pkg.sv
// Shared constants for the inverse S-box datapath: product, output and
// intermediate widths of one lane, plus the legal parameter ranges.
package sbox_pkg;

    localparam int M_WIDTH    = 63;
    localparam int W_WIDTH    = 8;
    localparam int P_COUNT    = 29;

    localparam int LANES_MIN  = 1;
    localparam int LANES_MAX  = 16;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 4;

    typedef logic [M_WIDTH-1:0] m_vec_t;
    typedef logic [W_WIDTH-1:0] w_vec_t;

endpackage

// File: rtl/bottom_linear_reverse.sv
// Depth-16 reverse bottom linear layer of one lane: maps the nonlinear
// products onto the eight inverse-S-box output bits using XOR only.
module bottom_linear_reverse
    import sbox_pkg::*;
(
    input  logic [M_WIDTH-1:0] m,
    output logic [W_WIDTH-1:0] w
);

    logic [P_COUNT-1:0] p;
    logic               unused_m;

    // Only the last eighteen products reach this layer; the rest feed
    // earlier parts of the S-box and are ignored here.
    assign unused_m = ^m[44:0];

    always_comb begin
        p = '0;
        w = '0;

        p[0]  = m[51] ^ m[60];
        p[1]  = m[57] ^ m[58];
        p[2]  = m[53] ^ m[61];
        p[3]  = m[46] ^ m[49];
        p[4]  = m[47] ^ m[55];
        p[5]  = m[45] ^ m[50];
        p[6]  = m[48] ^ m[59];
        p[7]  = p[0]  ^ p[1];
        p[8]  = m[49] ^ m[52];
        p[9]  = m[54] ^ m[62];
        p[10] = m[56] ^ p[4];
        p[11] = p[0]  ^ p[3];
        p[12] = m[45] ^ m[47];
        p[13] = m[48] ^ m[50];
        p[14] = m[48] ^ m[61];
        p[15] = m[53] ^ m[58];
        p[16] = m[56] ^ m[60];
        p[17] = m[57] ^ p[2];
        p[18] = m[62] ^ p[5];
        p[19] = p[2]  ^ p[3];
        p[20] = p[4]  ^ p[6];
        p[21] = p[2]  ^ p[7];
        p[22] = p[7]  ^ p[8];
        p[23] = p[5]  ^ p[7];
        p[24] = p[6]  ^ p[10];
        p[25] = p[9]  ^ p[11];
        p[26] = p[10] ^ p[18];
        p[27] = p[11] ^ p[24];
        p[28] = p[15] ^ p[20];

        // Output bit 7 carries W0 and bit 0 carries W7.
        w[7] = p[13] ^ p[21];
        w[6] = p[25] ^ p[28];
        w[5] = p[17] ^ p[27];
        w[4] = p[12] ^ p[21];
        w[3] = p[22] ^ p[26];
        w[2] = p[19] ^ p[23];
        w[1] = p[14] ^ p[22];
        w[0] = p[9]  ^ p[16];
    end

endmodule

// File: rtl/bottom_linear_pipe.sv
// Multi-lane reverse bottom linear transform followed by a valid/ready
// register pipeline and a free-running output handshake counter.
module bottom_linear_pipe
    import sbox_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 2
)
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [M_WIDTH*LANES-1:0]   in_m,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W_WIDTH*LANES-1:0]   out_w,
    output logic [31:0]                beat_count
);

    localparam int DATA_W = W_WIDTH * LANES;

    logic [DATA_W-1:0]      xform_w;
    logic [PIPE_STAGES:0]   stage_ready;
    logic [PIPE_STAGES-1:0] up_valid;
    logic [DATA_W-1:0]      up_data [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] valid_q;
    logic [PIPE_STAGES-1:0] valid_d;
    logic [DATA_W-1:0]      data_q  [PIPE_STAGES];
    logic [DATA_W-1:0]      data_d  [PIPE_STAGES];
    logic [31:0]            beat_count_q;
    logic [31:0]            beat_count_d;
    logic                   out_fire;

    // The transform sits ahead of the registers so they can be retimed into it.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        bottom_linear_reverse u_xform (
            .m (in_m[M_WIDTH*g +: M_WIDTH]),
            .w (xform_w[W_WIDTH*g +: W_WIDTH])
        );
    end

    always_comb begin
        stage_ready              = '0;
        stage_ready[PIPE_STAGES] = out_ready;
        for (int s = PIPE_STAGES - 1; s >= 0; s--) begin
            stage_ready[s] = !valid_q[s] || stage_ready[s+1];
        end
    end

    always_comb begin
        up_valid    = '0;
        up_valid[0] = in_valid;
        up_data[0]  = xform_w;
        for (int s = 1; s < PIPE_STAGES; s++) begin
            up_valid[s] = valid_q[s-1];
            up_data[s]  = data_q[s-1];
        end
    end

    always_comb begin
        valid_d = valid_q;
        for (int s = 0; s < PIPE_STAGES; s++) begin
            data_d[s] = data_q[s];
            if (stage_ready[s]) begin
                valid_d[s] = up_valid[s];
                data_d[s]  = up_data[s];
            end
        end
    end

    // Reset masks both handshakes so nothing is accepted or delivered that cycle.
    assign in_ready   = stage_ready[0] && !rst;
    assign out_valid  = valid_q[PIPE_STAGES-1] && !rst;
    assign out_fire   = out_valid && out_ready;
    assign out_w      = data_q[PIPE_STAGES-1];
    assign beat_count = beat_count_q;

    always_comb begin
        beat_count_d = beat_count_q + {31'b0, out_fire};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            beat_count_q <= '0;
        end else begin
            valid_q      <= valid_d;
            beat_count_q <= beat_count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < PIPE_STAGES; s++) begin
            data_q[s] <= data_d[s];
        end
    end

endmodule

// File: tb/tb_bottom_linear_pipe.sv
// Scoreboard bench for bottom_linear_pipe: predictions come from a per-product
// column table of the linear layer and are compared as beats leave the pipe.
module tb_bottom_linear_pipe;

    localparam int LANES  = 4;
    localparam int STAGES = 2;
    localparam int MW     = 63 * LANES;
    localparam int WW     = 8 * LANES;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] in_m;
    logic          out_valid;
    logic          out_ready;
    logic [WW-1:0] out_w;
    logic [31:0]   beat_count;

    int            assertCount = 0;
    int            failCount   = 0;
    logic [WW-1:0] expQ [$];
    logic [31:0]   expBeats;

    always #5 clk = ~clk;

    bottom_linear_pipe #(
        .LANES       (LANES),
        .PIPE_STAGES (STAGES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_m       (in_m),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_w      (out_w),
        .beat_count (beat_count)
    );

    // Response of the output byte to each single product bit.
    function automatic logic [7:0] columnOf(input int j);
        case (j)
            45: return 8'h1C;
            46: return 8'h64;
            47: return 8'h78;
            48: return 8'hE2;
            49: return 8'h6E;
            50: return 8'h8C;
            51: return 8'hFE;
            52: return 8'h0A;
            53: return 8'hF4;
            54: return 8'h41;
            55: return 8'h68;
            56: return 8'h29;
            57: return 8'hBE;
            58: return 8'hDE;
            59: return 8'h60;
            60: return 8'hFF;
            61: return 8'hB6;
            62: return 8'h49;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [WW-1:0] predict(input logic [MW-1:0] m);
        logic [WW-1:0] r;
        r = '0;
        for (int lane = 0; lane < LANES; lane++) begin
            for (int j = 0; j < 63; j++) begin
                if (m[63*lane + j]) r[8*lane +: 8] = r[8*lane +: 8] ^ columnOf(j);
            end
        end
        return r;
    endfunction

    function automatic logic [MW-1:0] randomM();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[32*i +: 32] = $urandom();
        return t[MW-1:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One cycle: drive at the falling edge, observe 1 ns later, then wait
    // for the next falling edge so the rising edge sees stable inputs.
    task automatic applyStimulus(input logic iv, input logic [MW-1:0] data, input logic ordy,
                                 output logic accepted, output logic sawValid, output logic [WW-1:0] sawData);
        in_valid  = iv;
        in_m      = data;
        out_ready = ordy;
        #1;
        sawValid = out_valid;
        sawData  = out_w;
        if (out_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious out_valid", 32'd1, 32'd0);
            end else begin
                checkOutput("out_w vs scoreboard", out_w, expQ[0]);
                if (out_ready) void'(expQ.pop_front());
            end
            if (out_ready) expBeats++;
        end
        accepted = in_valid && in_ready;
        if (accepted) expQ.push_back(predict(data));
        @(negedge clk);
    endtask

    task automatic drainPipe(input string tag);
        logic          a;
        logic          v;
        logic [WW-1:0] d;
        for (int n = 0; n < 64 && expQ.size() > 0; n++) applyStimulus(1'b0, '0, 1'b1, a, v, d);
        checkOutput({tag, " drain leftover"}, 32'(expQ.size()), 32'd0);
        checkOutput({tag, " beat_count"}, beat_count, expBeats);
    endtask

    task automatic measureLatency(input string tag, input logic [MW-1:0] data, input logic [WW-1:0] expected);
        logic          a;
        logic          v;
        logic [WW-1:0] d;
        logic [WW-1:0] obs;
        int            lat;
        lat = -1;
        obs = '0;
        applyStimulus(1'b1, data, 1'b1, a, v, d);
        checkOutput({tag, " accepted"}, {31'b0, a}, 32'd1);
        for (int n = 1; n <= 8 && lat < 0; n++) begin
            applyStimulus(1'b0, '0, 1'b1, a, v, d);
            if (v) begin
                lat = n;
                obs = d;
            end
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(STAGES));
        checkOutput({tag, " value"}, obs, expected);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic          a;
        logic          v;
        logic [WW-1:0] d;
        logic [MW-1:0] m;
        int            sent;
        int            accCount;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_m      = '0;
        out_ready = 1'b0;
        expBeats  = '0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, randomM(), 1'b1, a, v, d);
            checkOutput("reset in_ready", {31'b0, a}, 32'd0);
            checkOutput("reset out_valid", {31'b0, v}, 32'd0);
        end
        checkOutput("reset beat_count", beat_count, 32'd0);
        rst = 1'b0;

        measureLatency("zero input", '0, 32'h0000_0000);
        m = '0; m[62] = 1'b1;
        measureLatency("lane0 bit62", m, 32'h0000_0049);
        m = '0; m[51] = 1'b1;
        measureLatency("lane0 bit51", m, 32'h0000_00FE);
        m = '0; m[63*3 + 62] = 1'b1;
        measureLatency("lane3 bit62", m, 32'h4900_0000);
        m = '0; m[63*2 + 51] = 1'b1; m[63*1 + 62] = 1'b1;
        measureLatency("lane2 bit51 lane1 bit62", m, 32'h00FE_4900);

        sent = 0;
        for (int n = 0; n < 400 && sent < 16; n++) begin
            applyStimulus(1'b1, randomM(), 1'($urandom_range(0, 1)), a, v, d);
            if (a) sent++;
        end
        checkOutput("backpressure beats sent", 32'(sent), 32'd16);
        drainPipe("backpressure");

        sent = 0;
        for (int n = 0; n < 40000 && sent < 10000; n++) begin
            applyStimulus(1'($urandom_range(0, 9) < 8), randomM(), 1'($urandom_range(0, 9) < 8), a, v, d);
            if (a) sent++;
        end
        checkOutput("random beats sent", 32'(sent), 32'd10000);
        drainPipe("random");

        accCount = 0;
        for (int n = 0; n < 10; n++) begin
            applyStimulus(1'b1, randomM(), 1'b0, a, v, d);
            if (a) accCount++;
        end
        checkOutput("full accepts", 32'(accCount), 32'(STAGES));
        #1;
        checkOutput("full in_ready", {31'b0, in_ready}, 32'd0);
        drainPipe("full");

        for (int n = 0; n < STAGES; n++) applyStimulus(1'b1, randomM(), 1'b0, a, v, d);
        for (int n = 0; n < 5; n++) begin
            applyStimulus(1'b1, randomM(), 1'b1, a, v, d);
            checkOutput("full pass-through accept", {31'b0, a}, 32'd1);
        end
        drainPipe("pass-through");

        for (int n = 0; n < 3; n++) applyStimulus(1'b1, randomM(), 1'b0, a, v, d);
        rst = 1'b1;
        applyStimulus(1'b1, randomM(), 1'b1, a, v, d);
        checkOutput("mid reset accept", {31'b0, a}, 32'd0);
        checkOutput("mid reset out_valid", {31'b0, v}, 32'd0);
        rst = 1'b0;
        expQ.delete();
        expBeats = '0;
        #1;
        checkOutput("after reset out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("after reset beat_count", beat_count, 32'd0);
        m = '0; m[51] = 1'b1;
        measureLatency("post reset", m, 32'h0000_00FE);
        drainPipe("post reset");

        force dut.beat_count_q = 32'hFFFF_FFFE;
        applyStimulus(1'b0, '0, 1'b0, a, v, d);
        applyStimulus(1'b0, '0, 1'b0, a, v, d);
        release dut.beat_count_q;
        #1;
        checkOutput("wrap preload", beat_count, 32'hFFFF_FFFE);
        expBeats = 32'hFFFF_FFFE;
        sent = 0;
        for (int n = 0; n < 50 && sent < 3; n++) begin
            applyStimulus(1'b1, randomM(), 1'b1, a, v, d);
            if (a) sent++;
        end
        drainPipe("wrap");
        checkOutput("wrap beat_count", beat_count, 32'h0000_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
